datapath_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the register-bank/ALU datapath. Accepts one 16-bit

---
 rtl/datapath_ctrl_fsm_if.sv | 19 +
 rtl/datapath_ctrl_fsm.sv | 151 +++++++++++++++
 tb/tb_datapath_ctrl_fsm.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_fsm_if.sv
// Instruction handshake between the fetch source and the control sequencer.
// The source drives instr/instr_valid and holds them until instr_ready is seen.
interface datapath_ctrl_fsm_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/datapath_ctrl_fsm.sv
// Multi-cycle control sequencer for the register-bank/ALU datapath: accepts one instruction per
// handshake, decodes it, waits out stalls, latches ALU flags and pulses a single register write.
module datapath_ctrl_fsm #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_N  = 16,
    parameter int unsigned FLAG_W = 6,
    parameter logic [7:0]  CMP_R  = 8'h0B,
    parameter logic [7:0]  CMP_I  = 8'hB0
) (
    input  logic                 clk,
    input  logic                 reset,
    datapath_ctrl_fsm_if.slave   bus,
    input  logic                 stall,
    input  logic [FLAG_W-1:0]    flags_in,
    output logic [REG_N-1:0]     wEnable,
    output logic [DATA_W-1:0]    Imm_in,
    output logic [7:0]           opcode,
    output logic [7:0]           Rdest_select,
    output logic [7:0]           Rsrc_select,
    output logic                 Imm_select,
    output logic [FLAG_W-1:0]    psr,
    output logic                 done,
    output logic                 illegal
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DECODE    = 2'd1;
    localparam logic [1:0] EXECUTE   = 2'd2;
    localparam logic [1:0] WRITEBACK = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [3:0]        rdest_q, rdest_d;
    logic [3:0]        rsrc_q, rsrc_d;
    logic              imm_sel_q, imm_sel_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [FLAG_W-1:0] psr_q, psr_d;

    logic [3:0]        ir_op, ir_dst, ir_ext, ir_lo;
    logic              ext_ok;
    logic              zext_imm;
    logic              dec_illegal;
    logic [DATA_W-1:0] imm_ext;
    logic              is_cmp;

    assign ir_op  = ir_q[15:12];
    assign ir_dst = ir_q[11:8];
    assign ir_ext = ir_q[7:4];
    assign ir_lo  = ir_q[3:0];

    always_comb begin
        ext_ok = 1'b0;
        case (ir_ext)
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD: ext_ok = 1'b1;
            default:                                        ext_ok = 1'b0;
        endcase
    end

    // Logical immediates (and the 0xD form) take the byte unsigned; arithmetic ones sign-extend.
    always_comb begin
        zext_imm = 1'b0;
        case (ir_op)
            4'h1, 4'h2, 4'h3, 4'hD: zext_imm = 1'b1;
            default:                zext_imm = 1'b0;
        endcase
    end

    assign imm_ext     = zext_imm ? {{(DATA_W-8){1'b0}}, ir_q[7:0]}
                                  : {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign dec_illegal = (ir_op == 4'h0) && !ext_ok;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        opcode_d  = opcode_q;
        rdest_d   = rdest_q;
        rsrc_d    = rsrc_q;
        imm_sel_d = imm_sel_q;
        imm_d     = imm_q;
        psr_d     = psr_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                rdest_d = ir_dst;
                if (ir_op == 4'h0) begin
                    opcode_d  = {4'h0, ir_ext};
                    rsrc_d    = ir_lo;
                    imm_sel_d = 1'b1;
                    imm_d     = '0;
                end else begin
                    opcode_d  = {ir_op, 4'h0};
                    rsrc_d    = 4'h0;
                    imm_sel_d = 1'b0;
                    imm_d     = imm_ext;
                end
                state_d = dec_illegal ? IDLE : EXECUTE;
            end
            EXECUTE: begin
                if (!stall) begin
                    psr_d   = flags_in;
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            opcode_q  <= '0;
            rdest_q   <= '0;
            rsrc_q    <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            psr_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            rdest_q   <= rdest_d;
            rsrc_q    <= rsrc_d;
            imm_sel_q <= imm_sel_d;
            imm_q     <= imm_d;
            psr_q     <= psr_d;
        end
    end

    // Strobes decode straight from the state register so an async reset kills them at once.
    assign is_cmp          = (opcode_q == CMP_R) || (opcode_q == CMP_I);
    assign bus.instr_ready = (state_q == IDLE);
    assign done            = (state_q == WRITEBACK);
    assign illegal         = (state_q == DECODE) && dec_illegal;
    assign wEnable         = (done && !is_cmp) ? (REG_N'(1) << rdest_q) : '0;

    assign opcode       = opcode_q;
    assign Rdest_select = {4'h0, rdest_q};
    assign Rsrc_select  = {4'h0, rsrc_q};
    assign Imm_select   = imm_sel_q;
    assign Imm_in       = imm_q;
    assign psr          = psr_q;

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Self-checking bench: directed cases then randomized instructions with random stalls, checked
// cycle by cycle against a behavioural decode model and a tracked PSR value.
module tb_datapath_ctrl_fsm;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [5:0]  flags_in;
    logic [15:0] wEnable;
    logic [15:0] Imm_in;
    logic [7:0]  opcode;
    logic [7:0]  Rdest_select;
    logic [7:0]  Rsrc_select;
    logic        Imm_select;
    logic [5:0]  psr;
    logic        done;
    logic        illegal;

    int checks;
    int errors;
    logic [5:0] model_psr;

    datapath_ctrl_fsm_if bus ();

    datapath_ctrl_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .stall        (stall),
        .flags_in     (flags_in),
        .wEnable      (wEnable),
        .Imm_in       (Imm_in),
        .opcode       (opcode),
        .Rdest_select (Rdest_select),
        .Rsrc_select  (Rsrc_select),
        .Imm_select   (Imm_select),
        .psr          (psr),
        .done         (done),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference decode written from the instruction-set rules.
    task automatic model(input logic [15:0] ins, output logic [7:0] e_opc,
                         output logic [7:0] e_rsrc, output logic e_sel,
                         output logic [15:0] e_imm, output logic [15:0] e_wen,
                         output logic e_ill);
        int op, ext, lo, dst;
        op  = int'(ins[15:12]);
        dst = int'(ins[11:8]);
        ext = int'(ins[7:4]);
        lo  = int'(ins[3:0]);
        if (op == 0) begin
            e_opc  = 8'(ext);
            e_rsrc = 8'(lo);
            e_sel  = 1'b1;
            e_imm  = 16'h0000;
            e_ill  = !(ext inside {1, 2, 3, 5, 6, 9, 11, 13});
        end else begin
            e_opc  = 8'(op * 16);
            e_rsrc = 8'h00;
            e_sel  = 1'b0;
            if (op inside {1, 2, 3, 13}) e_imm = 16'(int'(ins[7:0]));
            else                         e_imm = 16'(int'($signed(ins[7:0])));
            e_ill  = 1'b0;
        end
        if (e_opc == 8'h0B || e_opc == 8'hB0) e_wen = 16'h0000;
        else                                  e_wen = 16'(1 << dst);
    endtask

    // Called just after a negedge in IDLE; returns just after the negedge back in IDLE.
    task automatic run_instr(input logic [15:0] ins, input int k, input logic [5:0] fl);
        logic [7:0]  e_opc, e_rsrc;
        logic        e_sel, e_ill;
        logic [15:0] e_imm, e_wen;
        model(ins, e_opc, e_rsrc, e_sel, e_imm, e_wen, e_ill);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        stall           = 1'b0;
        #1 chk("ready_idle", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        // Garbage on the handshake outside IDLE must be ignored.
        bus.instr_valid = 1'($urandom_range(0, 1));
        bus.instr       = 16'($urandom);
        #1;
        chk("illegal_decode", 32'(illegal), 32'(e_ill));
        chk("wen_decode", 32'(wEnable), 32'd0);
        chk("ready_decode", 32'(bus.instr_ready), 32'd0);
        if (e_ill) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            #1;
            chk("ready_after_illegal", 32'(bus.instr_ready), 32'd1);
            chk("illegal_one_cycle", 32'(illegal), 32'd0);
            chk("psr_after_illegal", 32'(psr), 32'(model_psr));
            chk("done_after_illegal", 32'(done), 32'd0);
            return;
        end
        for (int j = 0; j <= k; j++) begin
            @(negedge clk);
            stall    = (j < k);
            flags_in = (j < k) ? 6'($urandom) : fl;
            #1;
            chk("opcode", 32'(opcode), 32'(e_opc));
            chk("rdest", 32'(Rdest_select), 32'(ins[11:8]));
            chk("rsrc", 32'(Rsrc_select), 32'(e_rsrc));
            chk("imm_sel", 32'(Imm_select), 32'(e_sel));
            chk("imm_in", 32'(Imm_in), 32'(e_imm));
            chk("wen_exec", 32'(wEnable), 32'd0);
            chk("done_exec", 32'(done), 32'd0);
            chk("psr_hold", 32'(psr), 32'(model_psr));
        end
        @(negedge clk);
        model_psr = fl;
        stall     = 1'($urandom_range(0, 1));
        flags_in  = 6'($urandom);
        #1;
        chk("wen_wb", 32'(wEnable), 32'(e_wen));
        chk("done_wb", 32'(done), 32'd1);
        chk("psr_wb", 32'(psr), 32'(model_psr));
        chk("ready_wb", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        stall           = 1'b0;
        #1;
        chk("ready_after_wb", 32'(bus.instr_ready), 32'd1);
        chk("wen_after_wb", 32'(wEnable), 32'd0);
        chk("done_after_wb", 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] ins;
        checks          = 0;
        errors          = 0;
        model_psr       = 6'h00;
        reset           = 1'b0;
        stall           = 1'b0;
        flags_in        = 6'h00;
        bus.instr       = 16'h0000;
        bus.instr_valid = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_wen", 32'(wEnable), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_imm", 32'(Imm_in), 32'd0);
        chk("rst_psr", 32'(psr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_instr(16'h0355, 0, 6'h2A);
        run_instr(16'h52FF, 0, 6'h01);
        run_instr(16'h2180, 1, 6'h3F);
        run_instr(16'h04B6, 0, 6'h15);
        run_instr(16'hB3F0, 2, 6'h07);
        run_instr(16'hD0C3, 0, 6'h11);
        run_instr(16'h0355, 3, 6'h22);
        run_instr(16'h0740, 0, 6'h33);

        // Reset mid-EXECUTE aborts the instruction.
        bus.instr       = 16'h0355;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.instr_ready), 32'd1);
        chk("abort_wen", 32'(wEnable), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_psr", 32'(psr), 32'd0);
        chk("abort_opcode", 32'(opcode), 32'd0);
        model_psr = 6'h00;
        stall     = 1'b0;
        @(negedge clk);
        #1 chk("abort_wen_held", 32'(wEnable), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        run_instr(16'h0A11, 0, 6'h09);

        for (int n = 0; n < 60; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ins[15:12] = 4'h0;
            run_instr(ins, int'($urandom_range(0, 3)), 6'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
